// File: rtl/vectored_instruction_loader.sv
// vectored_instruction_loader: injects BRK opcodes for reset, NMI and IRQ entry and supervises each entry sequence
module vectored_instruction_loader #(
    parameter int IRQ_CHANNELS = 4,
    parameter int DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] BRK_OPCODE = '0,
    parameter int TIMEOUT_CYCLES = 15,
    localparam int CW = (IRQ_CHANNELS > 1) ? $clog2(IRQ_CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    enableFFs,
    input  logic                    nmiIn,
    input  logic [IRQ_CHANNELS-1:0] irqIn,
    input  logic [IRQ_CHANNELS-1:0] irqMask,
    input  logic                    processStatusRegIFlag,
    input  logic                    loadNextInstruction,
    input  logic [DATA_WIDTH-1:0]   externalDB,
    input  logic                    interruptFlagWasSet,
    output logic [DATA_WIDTH-1:0]   nextInstruction,
    output logic                    instructionRegReadEnable,
    output logic                    initiateInterruptWithPCDecrement,
    output logic                    enableIFlag,
    output logic                    resetRunning,
    output logic                    nmiRunning,
    output logic                    irqRunning,
    output logic [CW-1:0]           activeChannel,
    output logic [1:0]              vectorSelect,
    output logic                    sequenceTimeout
);
    localparam logic [2:0] RST_PEND = 3'd0, RST_RUN = 3'd1, IDLE = 3'd2, INT_PEND = 3'd3, INT_RUN = 3'd4;
    // source codes double as the vectorSelect encoding
    localparam logic [1:0] SRC_RST = 2'b00, SRC_NMI = 2'b01, SRC_IRQ = 2'b10;
    logic [2:0] state;
    logic [1:0] src, eff_src;
    logic [7:0] cnt;
    logic [IRQ_CHANNELS-1:0] irq_pending;
    logic [CW-1:0] low_channel;
    logic nmi_latched, nmi_prev, nmi_edge, irq_req, cancel, brk, inject_nmi, int_state, timeout_hit;

    assign irq_pending = irqIn & ~irqMask;
    assign irq_req = |irq_pending && !processStatusRegIFlag;
    assign nmi_edge = nmiIn && !nmi_prev;
    // a pending NMI pre-empts an IRQ entry that has not yet been loaded
    assign eff_src = (src == SRC_IRQ && (nmi_edge || nmi_latched)) ? SRC_NMI : src;
    assign cancel = state == INT_PEND && eff_src == SRC_IRQ && !irq_req;
    assign brk = state == INT_PEND && !cancel;
    assign inject_nmi = brk && loadNextInstruction && eff_src == SRC_NMI;
    assign int_state = state == INT_PEND || state == INT_RUN;
    assign timeout_hit = cnt + 8'd1 == 8'(TIMEOUT_CYCLES);

    assign nextInstruction = (state == RST_PEND || brk) ? BRK_OPCODE : externalDB;
    assign instructionRegReadEnable = state == RST_PEND || loadNextInstruction;
    assign initiateInterruptWithPCDecrement = brk && loadNextInstruction;
    assign enableIFlag = state == RST_PEND || state == RST_RUN || state == INT_RUN;
    assign resetRunning = state == RST_PEND || state == RST_RUN;
    assign nmiRunning = int_state && src == SRC_NMI;
    assign irqRunning = int_state && src == SRC_IRQ;
    assign vectorSelect = resetRunning ? SRC_RST : int_state ? src : 2'b11;

    // lowest-index unmasked request wins the channel grant
    always_comb begin
        low_channel = '0;
        for (int i = IRQ_CHANNELS - 1; i >= 0; i--)
            if (irq_pending[i]) low_channel = CW'(i);
    end

    // entry sequencer, NMI edge latch and timeout supervision
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= RST_PEND;
            src <= SRC_RST;
            cnt <= '0;
            nmi_latched <= 1'b0;
            nmi_prev <= 1'b0;
            activeChannel <= '0;
            sequenceTimeout <= 1'b0;
        end else if (enableFFs) begin
            nmi_prev <= nmiIn;
            if (inject_nmi) nmi_latched <= 1'b0;
            else if (nmi_edge) nmi_latched <= 1'b1;
            case (state)
                RST_PEND: begin
                    state <= RST_RUN;
                    cnt <= '0;
                end
                RST_RUN, INT_RUN: begin
                    cnt <= cnt + 8'd1;
                    if (interruptFlagWasSet) state <= IDLE;
                    else if (timeout_hit) begin
                        state <= IDLE;
                        sequenceTimeout <= 1'b1;
                    end
                end
                IDLE: begin
                    if (nmi_latched) begin
                        state <= INT_PEND;
                        src <= SRC_NMI;
                    end else if (irq_req) begin
                        state <= INT_PEND;
                        src <= SRC_IRQ;
                        activeChannel <= low_channel;
                    end
                end
                INT_PEND: begin
                    src <= eff_src;
                    if (eff_src == SRC_IRQ && irq_req) activeChannel <= low_channel;
                    if (cancel) state <= IDLE;
                    else if (loadNextInstruction) begin
                        state <= INT_RUN;
                        cnt <= '0;
                    end
                end
                default: state <= RST_PEND;
            endcase
        end
    end
endmodule

// File: tb/tb_vectored_instruction_loader.sv
// tb_vectored_instruction_loader: directed and randomized checks against a behavioural entry-sequence model
module tb_vectored_instruction_loader;
    localparam int N = 4;
    localparam int TO = 15;
    localparam logic [7:0] BRK = 8'h00;
    logic clk = 0, nrst = 0, en = 1, nmi = 0, iflag = 0, load = 0, ifws = 0;
    logic [N-1:0] irq = '0, mask = '0;
    logic [7:0] db = 8'hA9;
    logic [7:0] next_ins;
    logic ire, pcd, eif, rr, nr, ir, tmo;
    logic [1:0] chan, vsel;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    vectored_instruction_loader #(.IRQ_CHANNELS(N), .DATA_WIDTH(8), .BRK_OPCODE(BRK), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .nrst(nrst), .enableFFs(en), .nmiIn(nmi), .irqIn(irq), .irqMask(mask),
        .processStatusRegIFlag(iflag), .loadNextInstruction(load), .externalDB(db),
        .interruptFlagWasSet(ifws), .nextInstruction(next_ins), .instructionRegReadEnable(ire),
        .initiateInterruptWithPCDecrement(pcd), .enableIFlag(eif), .resetRunning(rr),
        .nmiRunning(nr), .irqRunning(ir), .activeChannel(chan), .vectorSelect(vsel),
        .sequenceTimeout(tmo)
    );

    // behavioural model: phase of the entry sequence, who asked for it (0 reset, 1 NMI, 2 IRQ)
    typedef enum int {RP, RR, ID, IP, IR} phase_t;
    phase_t ph;
    int who, ticks, ch, req, src_e;
    bit latched, prev, timed, e_nmi, drop, run;

    function automatic int pick();
        if (iflag) return -1;
        for (int i = 0; i < N; i++) if (irq[i] && !mask[i]) return i;
        return -1;
    endfunction

    function automatic void mreset();
        ph = RP; who = 0; ticks = 0; ch = 0; latched = 0; prev = 0; timed = 0;
    endfunction

    function automatic void derive();
        req = pick();
        e_nmi = nmi && !prev;
        src_e = (who == 2 && (e_nmi || latched)) ? 1 : who;
        drop = ph == IP && src_e == 2 && req < 0;
        run = ph == IP || ph == IR;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic compare();
        derive();
        check("nextInstruction", next_ins, (ph == RP || (ph == IP && !drop)) ? BRK : db);
        check("irReadEnable", ire, ph == RP || load);
        check("pcDecrement", pcd, ph == IP && !drop && load);
        check("enableIFlag", eif, ph inside {RP, RR, IR});
        check("resetRunning", rr, ph == RP || ph == RR);
        check("nmiRunning", nr, run && who == 1);
        check("irqRunning", ir, run && who == 2);
        check("vectorSelect", vsel, (ph == RP || ph == RR) ? 0 : run ? who : 3);
        check("activeChannel", chan, ch);
        check("sequenceTimeout", tmo, timed);
    endtask

    task automatic advance();
        bit was_latched;
        derive();
        was_latched = latched;
        prev = nmi;
        if (e_nmi) latched = 1;
        case (ph)
            RP: begin ph = RR; ticks = 0; end
            RR, IR: begin
                ticks++;
                if (ifws) ph = ID;
                else if (ticks == TO) begin ph = ID; timed = 1; end
            end
            ID: if (was_latched) begin ph = IP; who = 1; end
                else if (req >= 0) begin ph = IP; who = 2; ch = req; end
            IP: begin
                who = src_e;
                if (src_e == 2 && req >= 0) ch = req;
                if (drop) ph = ID;
                else if (load) begin
                    ph = IR; ticks = 0;
                    if (src_e == 1) latched = 0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        #1 compare();
        @(posedge clk);
        if (nrst && en) advance();
        @(negedge clk);
    endtask

    initial begin
        mreset();
        @(negedge clk);
        #1;
        check("rst_next", next_ins, 8'h00);
        check("rst_ire", ire, 1);
        check("rst_vsel", vsel, 0);
        check("rst_pcd", pcd, 0);
        nrst = 1;
        tick();
        check("rstrun_rr", rr, 1);
        check("rstrun_next", next_ins, 8'hA9);
        ifws = 1; tick(); ifws = 0; #1;
        check("idle_next", next_ins, 8'hA9);
        check("idle_vsel", vsel, 3);
        // flag set on the same edge the count expires
        irq = 4'b0001; tick();
        load = 1; tick();
        load = 0; irq = '0;
        for (int k = 0; k < 14; k++) tick();
        ifws = 1; tick(); ifws = 0; #1;
        check("race_tmo", tmo, 0);
        check("race_vsel", vsel, 3);
        // IRQ on channels 1 and 3
        irq = 4'b1010; tick(); #1;
        check("irq_chan", chan, 1);
        check("irq_run", ir, 1);
        load = 1; #1;
        check("irq_pcd", pcd, 1);
        check("irq_brk", next_ins, 8'h00);
        tick();
        load = 0; irq = '0; ifws = 1; tick(); ifws = 0;
        // NMI pre-empts a pending IRQ
        irq = 4'b1000; tick(); #1;
        check("pre_chan", chan, 3);
        nmi = 1; tick(); #1;
        check("pre_nmi", nr, 1);
        check("pre_vsel", vsel, 1);
        check("pre_irq", ir, 0);
        load = 1; tick();
        load = 0; irq = '0; nmi = 0; ifws = 1; tick(); ifws = 0; tick(); #1;
        check("nmi_once", vsel, 3);
        // IRQ withdrawn before load
        irq = 4'b0100; tick();
        irq = '0; db = 8'h5C; #1;
        check("drop_next", next_ins, 8'h5C);
        check("drop_pcd", pcd, 0);
        tick(); #1;
        check("drop_idle", vsel, 3);
        db = 8'hA9;
        // NMI during IRQ service is held until IDLE
        irq = 4'b0001; tick();
        load = 1; tick();
        load = 0; irq = '0; nmi = 1; tick();
        nmi = 0; tick(); #1;
        check("held_irq", ir, 1);
        ifws = 1; tick(); ifws = 0; #1;
        check("held_idle", vsel, 3);
        tick(); #1;
        check("held_nmi", nr, 1);
        check("held_vsel", vsel, 1);
        load = 1; tick();
        load = 0; ifws = 1; tick(); ifws = 0;
        // timeout with a frozen stretch of disabled cycles
        irq = 4'b0001; tick();
        load = 1; tick();
        load = 0; irq = '0;
        for (int k = 0; k < 5; k++) tick();
        en = 0;
        for (int k = 0; k < 20; k++) tick();
        en = 1; #1;
        check("frz_eif", eif, 1);
        check("frz_tmo", tmo, 0);
        for (int k = 0; k < 9; k++) tick();
        #1 check("pre_to", tmo, 0);
        tick(); #1;
        check("to_set", tmo, 1);
        check("to_idle", vsel, 3);
        // reset mid-sequence
        irq = 4'b0010; tick();
        nmi = 1; nrst = 0; mreset(); #1;
        check("mid_rr", rr, 1);
        check("mid_tmo", tmo, 0);
        check("mid_chan", chan, 0);
        irq = '0; nmi = 0; tick();
        nrst = 1; tick();
        ifws = 1; tick(); ifws = 0; tick(); #1;
        check("mid_clean", vsel, 3);
        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            en = $urandom_range(0, 7) != 0;
            if ($urandom_range(0, 5) == 0) nmi = ~nmi;
            irq = $urandom_range(0, 1) ? N'($urandom) : '0;
            mask = N'($urandom);
            iflag = $urandom_range(0, 3) == 0;
            load = $urandom_range(0, 2) == 0;
            ifws = $urandom_range(0, 9) == 0;
            db = 8'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                nrst = 0;
                mreset();
            end else nrst = 1;
            tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vectored_instruction_loader.md
VECTORED_INSTRUCTION_LOADER -- requirements
Module: vectored_instruction_loader

Interface
REQ-001 The block SHALL have parameter IRQ_CHANNELS, default 4 (range 1..16): number of maskable interrupt request lines.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8: opcode and data bus width.
REQ-003 The block SHALL have parameter BRK_OPCODE, default 0: opcode injected for reset and interrupt entry.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 15 (range 1..255): enabled-cycle limit for an entry sequence.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port nrst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port enableFFs, input, 1 bit: clock enable that gates every state update.
REQ-008 The block SHALL have port nmiIn, input, 1 bit: non-maskable request, rising-edge sensitive.
REQ-009 The block SHALL have port irqIn, input, IRQ_CHANNELS bits: maskable requests, level sensitive, active-high.
REQ-010 The block SHALL have port irqMask, input, IRQ_CHANNELS bits: 1 masks the corresponding channel.
REQ-011 The block SHALL have port processStatusRegIFlag, input, 1 bit: CPU I flag; 1 blocks all IRQs.
REQ-012 The block SHALL have port loadNextInstruction, input, 1 bit: the core requests the next opcode.
REQ-013 The block SHALL have port externalDB, input, DATA_WIDTH bits: external data bus.
REQ-014 The block SHALL have port interruptFlagWasSet, input, 1 bit: the core has written the I flag.
REQ-015 The block SHALL have port nextInstruction, output, DATA_WIDTH bits: opcode presented to the instruction register.
REQ-016 The block SHALL have port instructionRegReadEnable, output, 1 bit: load strobe for the instruction register.
REQ-017 The block SHALL have port initiateInterruptWithPCDecrement, output, 1 bit: the injected BRK is being loaded.
REQ-018 The block SHALL have port enableIFlag, output, 1 bit: asks the core to set the I flag.
REQ-019 The block SHALL have ports resetRunning, nmiRunning and irqRunning, each output, 1 bit: the active entry source.
REQ-020 The block SHALL have port activeChannel, output, $clog2(IRQ_CHANNELS) bits (minimum 1): the serviced IRQ channel.
REQ-021 The block SHALL have port vectorSelect, output, 2 bits: 00 reset, 01 NMI, 10 IRQ, 11 idle.
REQ-022 The block SHALL have port sequenceTimeout, output, 1 bit: sticky error flag.

Function
REQ-023 The FSM SHALL have states RST_PEND, RST_RUN, IDLE, INT_PEND and INT_RUN, and every transition SHALL occur only on a clk edge with enableFFs=1.
REQ-024 NMI detection SHALL register nmiIn each enabled cycle and set nmiLatched when nmiIn=1 and the registered previous value is 0; nmiLatched SHALL hold until the NMI is injected.
REQ-025 The IRQ request SHALL be irqReq = |(irqIn & ~irqMask) & ~processStatusRegIFlag, and the granted channel SHALL be the lowest set index.
REQ-026 Priority SHALL be reset > NMI > IRQ.
REQ-027 By default, nextInstruction SHALL equal externalDB and instructionRegReadEnable SHALL equal loadNextInstruction.
REQ-028 In RST_PEND:
- instructionRegReadEnable SHALL be 1 and nextInstruction SHALL be BRK_OPCODE.
- The next enabled edge SHALL move the FSM to RST_RUN.
REQ-029 In RST_RUN, the FSM SHALL move to IDLE on interruptFlagWasSet=1.
REQ-030 In IDLE:
- nmiLatched=1 SHALL capture source NMI and move to INT_PEND.
- Otherwise, irqReq=1 SHALL capture source IRQ and activeChannel and move to INT_PEND.
REQ-031 In INT_PEND:
- nextInstruction SHALL be BRK_OPCODE.
- initiateInterruptWithPCDecrement SHALL equal loadNextInstruction.
- An edge with loadNextInstruction=1 SHALL move the FSM to INT_RUN, and SHALL clear nmiLatched if the source is NMI.
REQ-032 A new NMI edge during INT_PEND with an IRQ source SHALL change the source to NMI with no extra cycle.
REQ-033 An IRQ source whose irqReq has dropped in INT_PEND before loadNextInstruction SHALL cancel entry and return the FSM to IDLE with no BRK injected.
REQ-034 A changed IRQ channel during INT_PEND SHALL re-capture activeChannel; activeChannel SHALL be frozen in INT_RUN.
REQ-035 In INT_RUN, the FSM SHALL move to IDLE on interruptFlagWasSet=1; NMI edges seen in INT_RUN SHALL stay latched and be serviced from IDLE.
REQ-036 enableIFlag SHALL be 1 in RST_PEND, RST_RUN and INT_RUN, and 0 otherwise.
REQ-037 resetRunning SHALL be 1 in RST_PEND and RST_RUN; nmiRunning and irqRunning SHALL be 1 in INT_PEND and INT_RUN per the captured source.
REQ-038 The timeout counter SHALL be 8 bits, clear on entry to RST_RUN or INT_RUN, and increment on each enabled cycle in those states.
REQ-039 When the count reaches TIMEOUT_CYCLES without interruptFlagWasSet, sequenceTimeout SHALL set and the FSM SHALL move to IDLE; sequenceTimeout SHALL clear only on reset.
REQ-040 interruptFlagWasSet arriving on the same edge the count reaches TIMEOUT_CYCLES SHALL win, and sequenceTimeout SHALL stay 0.
REQ-041 With enableFFs=0, the combinational outputs SHALL still follow the current state and inputs.

Reset
REQ-042 When nrst=0, the block SHALL immediately force:
- state RST_PEND;
- nmiLatched, previous nmiIn, timeout counter, activeChannel and sequenceTimeout to 0;
- source to reset.
REQ-043 Reset-value outputs SHALL be:
- instructionRegReadEnable=1, nextInstruction=BRK_OPCODE;
- enableIFlag=1, resetRunning=1, nmiRunning=0, irqRunning=0;
- vectorSelect=00, initiateInterruptWithPCDecrement=0.
REQ-044 Reset asserted mid-sequence SHALL abort the sequence and discard any pending NMI or IRQ.

Verification
REQ-045 Reset release, enableFFs=1, externalDB=0xA9 -> one cycle with nextInstruction=0x00 and read enable=1; then RST_RUN; interruptFlagWasSet -> IDLE, nextInstruction=0xA9.
REQ-046 IDLE, irqIn=0b1010, irqMask=0, I=0 -> activeChannel=1, irqRunning=1; loadNextInstruction=1 -> initiateInterruptWithPCDecrement=1, nextInstruction=0x00.
REQ-047 IRQ on channel 3 in INT_PEND plus nmiIn 0->1 -> nmiRunning=1, vectorSelect=01, irqRunning=0.
REQ-048 irqIn drops to 0 in INT_PEND before loadNextInstruction -> IDLE, nextInstruction=externalDB, no PC-decrement strobe.
REQ-049 INT_RUN with interruptFlagWasSet held 0 for 15 enabled cycles -> sequenceTimeout=1, IDLE; with enableFFs=0 for 20 cycles -> state and counter unchanged.
REQ-050 nmiIn pulses during INT_RUN of an IRQ -> after interruptFlagWasSet, IDLE, then INT_PEND with source NMI on the next enabled cycle.
